// File: rtl/entry_access_arbiter.sv
// Two-way arbiter for the shared access resource between entry interfaces IE01 and IE02.
// Higher user code wins; ties alternate; grants end on done, withdrawal or hold timeout.
module entry_access_arbiter #(
    parameter int HOLD_MAX = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req1,
    input  logic [2:0] code1,
    input  logic       req2,
    input  logic [2:0] code2,
    input  logic       done,
    output logic       gnt1,
    output logic       gnt2,
    output logic [2:0] gnt_code,
    output logic       busy,
    output logic       timeout
);

    localparam int CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT1  = 2'd1;
    localparam logic [1:0] S_GRANT2  = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          last_served, last_served_d;   // 0 = IE01, 1 = IE02
    logic          gnt1_d, gnt2_d, busy_d, timeout_d;
    logic [2:0]    gnt_code_d;

    logic valid1, valid2, pick1, pick2, served_req;

    assign valid1 = req1 && (code1 != 3'd0);
    assign valid2 = req2 && (code2 != 3'd0);

    // Equal codes go to whichever side was not served last.
    assign pick1 = valid1 && (!valid2 || (code1 > code2) ||
                              ((code1 == code2) && last_served));
    assign pick2 = valid2 && !pick1;

    assign served_req = (state == S_GRANT1) ? req1 : req2;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_d       = state;
        cnt_d         = cnt;
        last_served_d = last_served;
        gnt1_d        = 1'b0;
        gnt2_d        = 1'b0;
        gnt_code_d    = 3'd0;
        busy_d        = 1'b0;
        timeout_d     = 1'b0;

        case (state)
            S_IDLE: begin
                if (pick1) begin
                    state_d       = S_GRANT1;
                    gnt1_d        = 1'b1;
                    gnt_code_d    = code1;
                    busy_d        = 1'b1;
                    last_served_d = 1'b0;
                    cnt_d         = '0;
                end else if (pick2) begin
                    state_d       = S_GRANT2;
                    gnt2_d        = 1'b1;
                    gnt_code_d    = code2;
                    busy_d        = 1'b1;
                    last_served_d = 1'b1;
                    cnt_d         = '0;
                end
            end

            S_GRANT1, S_GRANT2: begin
                busy_d = 1'b1;
                if (done || !served_req) begin
                    state_d = S_RELEASE;
                end else if (cnt == HOLD_LAST) begin
                    // Forced end: the grant has been high for HOLD_MAX cycles.
                    state_d   = S_RELEASE;
                    timeout_d = 1'b1;
                end else begin
                    gnt1_d     = gnt1;
                    gnt2_d     = gnt2;
                    gnt_code_d = gnt_code;
                    cnt_d      = cnt + CW'(1);
                end
            end

            S_RELEASE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            last_served <= 1'b1;
            gnt1        <= 1'b0;
            gnt2        <= 1'b0;
            gnt_code    <= 3'd0;
            busy        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            last_served <= last_served_d;
            gnt1        <= gnt1_d;
            gnt2        <= gnt2_d;
            gnt_code    <= gnt_code_d;
            busy        <= busy_d;
            timeout     <= timeout_d;
        end
    end

endmodule

// File: tb/tb_entry_access_arbiter.sv
// Directed self-checking bench for entry_access_arbiter with HOLD_MAX=8.
module tb_entry_access_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req1, req2, done;
    logic [2:0] code1, code2;
    logic       gnt1, gnt2, busy, timeout;
    logic [2:0] gnt_code;

    int vectors     = 0;
    int miscompares = 0;

    entry_access_arbiter #(.HOLD_MAX(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req1     (req1),
        .code1    (code1),
        .req2     (req2),
        .code2    (code2),
        .done     (done),
        .gnt1     (gnt1),
        .gnt2     (gnt2),
        .gnt_code (gnt_code),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic e1, input logic e2,
                         input logic [2:0] ec, input logic eb, input logic et);
        logic [6:0] obs, exp;
        obs = {gnt1, gnt2, gnt_code, busy, timeout};
        exp = {e1, e2, ec, eb, et};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed gnt1,gnt2,code,busy,timeout=%b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req1 = 1'b0; code1 = 3'd0;
        req2 = 1'b0; code2 = 3'd0;
        done = 1'b0;

        // Reset state
        tick(); tick();
        check("reset", 0, 0, 3'd0, 0, 0);
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", 0, 0, 3'd0, 0, 0);

        // Single request: grant next cycle, held, then done -> RELEASE -> IDLE
        req1 = 1'b1; code1 = 3'd5;
        tick();
        check("single_grant", 1, 0, 3'd5, 1, 0);
        tick();
        check("single_hold", 1, 0, 3'd5, 1, 0);
        done = 1'b1;
        tick();
        check("single_release", 0, 0, 3'd0, 1, 0);
        done = 1'b0; req1 = 1'b0;
        tick();
        check("single_idle", 0, 0, 3'd0, 0, 0);

        // Priority: code 6 beats code 3; IE01 served at M+3
        req1 = 1'b1; code1 = 3'd3;
        req2 = 1'b1; code2 = 3'd6;
        tick();
        check("prio_grant2", 0, 1, 3'd6, 1, 0);
        done = 1'b1;
        tick();
        check("prio_release", 0, 0, 3'd0, 1, 0);
        done = 1'b0; req2 = 1'b0;
        tick();
        check("prio_idle", 0, 0, 3'd0, 0, 0);
        tick();
        check("prio_grant1_m3", 1, 0, 3'd3, 1, 0);

        // Withdrawal: drop req1 -> RELEASE without timeout
        req1 = 1'b0;
        tick();
        check("withdraw_release", 0, 0, 3'd0, 1, 0);
        tick();
        check("withdraw_idle", 0, 0, 3'd0, 0, 0);

        // Tie alternation at code 4; IE01 was served last, so IE02 goes first
        req1 = 1'b1; code1 = 3'd4;
        req2 = 1'b1; code2 = 3'd4;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i % 2 == 0)
                check($sformatf("tie_grant_%0d", i), 0, 1, 3'd4, 1, 0);
            else
                check($sformatf("tie_grant_%0d", i), 1, 0, 3'd4, 1, 0);
            done = 1'b1;
            tick();
            check($sformatf("tie_release_%0d", i), 0, 0, 3'd0, 1, 0);
            done = 1'b0;
            tick();
            check($sformatf("tie_idle_%0d", i), 0, 0, 3'd0, 0, 0);
        end
        req1 = 1'b0; req2 = 1'b0;
        code1 = 3'd0; code2 = 3'd0;

        // Timeout: gnt1 high exactly 8 cycles, then timeout pulse with RELEASE
        req1 = 1'b1; code1 = 3'd2;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("to_hold_%0d", k), 1, 0, 3'd2, 1, 0);
        end
        tick();
        check("to_pulse", 0, 0, 3'd0, 1, 1);
        tick();
        check("to_idle", 0, 0, 3'd0, 0, 0);
        tick();
        check("to_regrant", 1, 0, 3'd2, 1, 0);

        // Code change mid-grant is ignored; done on the last hold cycle suppresses timeout
        code1 = 3'd7;
        tick();
        check("code_latched", 1, 0, 3'd2, 1, 0);
        for (int k = 3; k <= 8; k++) tick();
        check("done_at_limit_hold", 1, 0, 3'd2, 1, 0);
        done = 1'b1;
        tick();
        check("done_beats_timeout", 0, 0, 3'd0, 1, 0);
        done = 1'b0; req1 = 1'b0; code1 = 3'd0;
        tick();
        check("done_idle", 0, 0, 3'd0, 0, 0);

        // Code 0 is not a valid request
        req2 = 1'b1; code2 = 3'd0;
        tick(); tick();
        check("code0_no_grant", 0, 0, 3'd0, 0, 0);

        // Async reset mid-grant
        code2 = 3'd3;
        tick();
        check("pre_reset_grant2", 0, 1, 3'd3, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 0, 0, 3'd0, 0, 0);
        req1 = 1'b1; code1 = 3'd7;
        req2 = 1'b1; code2 = 3'd7;
        tick();
        check("reset_held", 0, 0, 3'd0, 0, 0);
        rst_n = 1'b1;
        tick();
        check("post_reset_tie_ie01", 1, 0, 3'd7, 1, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        check("post_reset_tie_ie02", 0, 1, 3'd7, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
